// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter; frame format latched per frame at START
// ports: clk, reset (sync, active-high); tx_valid/tx_ready/tx_data producer handshake;
//        cfg_div/cfg_bits/cfg_parity/cfg_stop2 frame format; uart_txd serial line (idles high);
//        uart_tx_busy FIFO or FSM active; fifo_level FIFO occupancy
module uart_tx_fifo #(
  parameter int DATA_W = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  input  logic [DATA_W-1:0]            tx_data,
  input  logic [DIV_W-1:0]             cfg_div,
  input  logic [3:0]                   cfg_bits,
  input  logic [1:0]                   cfg_parity,
  input  logic                         cfg_stop2,
  output logic                         uart_txd,
  output logic                         uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [LW-1:0] count;
  logic full, empty, push, pop, tick, txd_n, txd_q;
  logic [DIV_W-1:0] cnt, div_q, eff_div;
  logic [3:0] bit_idx, bits_q, eff_bits;
  logic [DATA_W-1:0] shift, head, mask;
  logic par_en_q, par_q, stop2_q;
  assign full = count == LW'(FIFO_DEPTH);
  assign empty = count == '0;
  assign tx_ready = !full && !reset;
  assign push = tx_valid && tx_ready;
  assign head = mem[rptr];
  assign fifo_level = count;
  assign uart_txd = txd_q;
  assign uart_tx_busy = !empty || state != IDLE;
  assign eff_div = cfg_div < DIV_W'(2) ? DIV_W'(2) : cfg_div;
  assign eff_bits = cfg_bits < 4'd5 ? 4'd5 : cfg_bits > 4'(DATA_W) ? 4'(DATA_W) : cfg_bits;
  assign tick = cnt == div_q - DIV_W'(1);
  // mask selects the payload bits that go on the line, for the parity computed at latch time
  for (genvar i = 0; i < DATA_W; i++) begin : g_mask
    assign mask[i] = 4'(i) < eff_bits;
  end
  always_comb begin
    state_n = state;
    pop = 1'b0;
    case (state)
      IDLE:
        if (!empty) begin
          state_n = START;
          pop = 1'b1;
        end
      START:
        if (tick) state_n = DATA;
      DATA:
        if (tick && bit_idx == bits_q - 4'd1) state_n = par_en_q ? PARITY : STOP;
      PARITY:
        if (tick) state_n = STOP;
      STOP:
        // last stop bit: chain straight into the next frame when data is waiting
        if (tick && bit_idx == {3'b000, stop2_q}) begin
          state_n = empty ? IDLE : START;
          pop = !empty;
        end
      default:
        state_n = IDLE;
    endcase
  end
  assign txd_n = state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par_q : 1'b1;
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= tx_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      cnt <= '0;
      bit_idx <= '0;
      txd_q <= 1'b1;
      div_q <= DIV_W'(2);
      bits_q <= 4'd5;
      shift <= '0;
      par_en_q <= 1'b0;
      par_q <= 1'b0;
      stop2_q <= 1'b0;
    end else begin
      txd_q <= txd_n;
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + LW'(push) - LW'(pop);
      cnt <= (state == IDLE || tick) ? '0 : cnt + DIV_W'(1);
      bit_idx <= state_n != state ? '0 : tick ? bit_idx + 4'd1 : bit_idx;
      if (pop) begin
        shift <= head;
        div_q <= eff_div;
        bits_q <= eff_bits;
        par_en_q <= ^cfg_parity;
        par_q <= ^(head & mask) ^ cfg_parity[1];
        stop2_q <= cfg_stop2;
      end else if (state == DATA && tick) begin
        shift <= shift >> 1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized bench for uart_tx_fifo against a frame-scheduling reference model
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;
  logic clk, reset, tx_valid, tx_ready, cfg_stop2, uart_txd, uart_tx_busy;
  logic [8:0] tx_data;
  logic [15:0] cfg_div;
  logic [3:0] cfg_bits;
  logic [1:0] cfg_parity;
  logic [2:0] fifo_level;
  int n_chk = 0, n_fail = 0, cyc = 0, max_lvl = 0;
  bit armed = 0;
  typedef struct {int s; int e; int ed; logic [15:0] b;} frame_t;
  frame_t cur = '{0, 0, 2, '1}, prv = '{0, 0, 2, '1};
  logic [8:0] q[$];

  uart_tx_fifo dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .cfg_div(cfg_div), .cfg_bits(cfg_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .uart_txd(uart_txd), .uart_tx_busy(uart_tx_busy), .fifo_level(fifo_level)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Frame as the line should carry it: start, eff_bits payload LSB first, optional parity, stop bits.
  function automatic frame_t mk_frame(input logic [8:0] d, input int t);
    frame_t f;
    int eb, n, ones;
    bit pe;
    f.ed = cfg_div < 2 ? 2 : int'(cfg_div);
    eb = cfg_bits < 5 ? 5 : cfg_bits > 9 ? 9 : int'(cfg_bits);
    pe = cfg_parity == 2'b01 || cfg_parity == 2'b10;
    f.b = '1;
    f.b[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < eb; i++) begin
      f.b[1+i] = d[i];
      ones += int'(d[i]);
    end
    n = 1 + eb;
    if (pe) begin
      f.b[n] = ((ones % 2) == 1) ^ (cfg_parity == 2'b10);
      n++;
    end
    n += cfg_stop2 ? 2 : 1;
    f.s = t;
    f.e = t + f.ed * n;
    return f;
  endfunction

  function automatic logic line_at(input frame_t f, input int u);
    return (u > f.s && u <= f.e) ? f.b[(u - f.s - 1) / f.ed] : 1'b1;
  endfunction

  // A frame starts at the first edge where data is queued and the previous frame has ended.
  always @(posedge clk) begin
    bit acc;
    cyc++;
    if (reset) begin
      q.delete();
      cur = '{0, 0, 2, '1};
      prv = cur;
      armed = 1;
    end else begin
      acc = tx_valid && q.size() < DEPTH;
      if (q.size() != 0 && cyc >= cur.e) begin
        prv = cur;
        cur = mk_frame(q.pop_front(), cyc);
      end
      if (acc) q.push_back(tx_data);
    end
  end

  always @(posedge clk) begin
    #1;
    if (armed) begin
      check("txd", uart_txd, (cyc > cur.s && cyc <= cur.e) ? line_at(cur, cyc) : line_at(prv, cyc));
      check("busy", uart_tx_busy, q.size() != 0 || (cyc >= cur.s && cyc < cur.e));
      check("level", fifo_level, q.size());
      check("ready", tx_ready, q.size() < DEPTH && !reset);
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
    end
  end

  task automatic send(input logic [8:0] d);
    int g = 0;
    tx_valid = 1;
    tx_data = d;
    while (!tx_ready && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("send_ready", tx_ready, 1'b1);
    @(negedge clk);
    tx_valid = 0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (uart_tx_busy && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("idle", uart_tx_busy, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; tx_valid = 0; tx_data = 0;
    cfg_div = 4; cfg_bits = 8; cfg_parity = 0; cfg_stop2 = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    send(9'h055); wait_idle();
    cfg_parity = 2'b01; send(9'h007); wait_idle();
    cfg_parity = 2'b10; send(9'h007); wait_idle();
    cfg_parity = 2'b00; cfg_bits = 7; cfg_stop2 = 1; send(9'h0FF); wait_idle();
    cfg_bits = 8; cfg_stop2 = 0; cfg_div = 2; max_lvl = 0;
    for (int k = 0; k < 6; k++) send(9'($urandom));
    wait_idle();
    check("max_level", max_lvl, DEPTH);
    cfg_div = 4;
    for (int k = 0; k < 3; k++) send(9'($urandom));
    repeat (12) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    repeat (60) @(negedge clk);
    cfg_div = 0; send(9'h0A5); wait_idle();
    cfg_div = 1; send(9'h05A); wait_idle();
    cfg_div = 3; send(9'h0C3);
    repeat (5) @(negedge clk);
    cfg_div = 7; wait_idle();
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(3) == 0) begin
        cfg_div = 16'($urandom_range(6));
        cfg_bits = 4'($urandom_range(15));
        cfg_parity = 2'($urandom_range(3));
        cfg_stop2 = 1'($urandom_range(1));
      end
      if ($urandom_range(59) == 0) begin
        reset = 1;
        @(negedge clk);
        reset = 0;
      end
      send(9'($urandom));
      repeat ($urandom_range(30)) @(negedge clk);
    end
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
